// File: rtl/vga_term_ctrl_pkg.sv
// Shared constants and types for the 70x30 VGA text terminal controller.
// Scrolling is enabled by defining VGA_TERM_SCROLL_EN.
package vga_term_ctrl_pkg;

    localparam int TERM_W = 70;
    localparam int TERM_H = 30;
    localparam int TERM_N = TERM_W * TERM_H;

    localparam logic [11:0] TERM_W12 = 12'(TERM_W);
    localparam logic [11:0] TERM_N12 = 12'(TERM_N);
    localparam logic [11:0] LAST_ROW_IDX = 12'(TERM_N - TERM_W);

    localparam logic [7:0] FILL_CHAR = 8'h20;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_BS     = 8'h08;
    localparam logic [7:0] PRINT_LO  = 8'h20;
    localparam logic [7:0] PRINT_HI  = 8'h7E;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_SCROLL_CLR
    } state_t;

    // Logical-to-physical mapping with a single compare-subtract.
    function automatic logic [11:0] wrap_addr(input logic [11:0] idx,
                                              input logic [11:0] base);
        logic [12:0] sum;
        sum = {1'b0, idx} + {1'b0, base};
        if (sum >= 13'(TERM_N))
            sum = sum - 13'(TERM_N);
        return sum[11:0];
    endfunction

endpackage

// File: rtl/vga_term_ctrl_ram.sv
// Simple dual-port text RAM, 2100x8: one write port, one registered read port.
// Unaffected by VGA_TERM_SCROLL_EN.
module term_ram
    import vga_term_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        wr_en,
    input  logic [11:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic [11:0] rd_addr,
    output logic [7:0]  rd_data
);

    logic [7:0] mem [0:TERM_N-1];

    // Read-before-write: a same-cycle read of the written cell sees old data.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vga_term_ctrl.sv
// Character-buffer controller: byte stream in, cursor/scroll handling, text RAM.
// Define VGA_TERM_SCROLL_EN to scroll on newline at the last row.
module vga_term_ctrl
    import vga_term_ctrl_pkg::*;
(
    input  logic        clk_50M,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_char,
    input  logic [11:0] disp_idx,
    output logic [7:0]  disp_char,
    output logic [4:0]  cur_row,
    output logic [6:0]  cur_col,
    output logic        busy
);

    state_t      state, state_n;
    logic [11:0] cnt, cnt_n;
    logic [4:0]  row, row_n;
    logic [6:0]  col, col_n;
    logic        fill_q;

    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [11:0] rd_addr;
    logic [7:0]  ram_q;
    logic [11:0] cur_idx;
    logic        accept;
    logic        do_nl;
    logic        disp_oor;

`ifdef VGA_TERM_SCROLL_EN
    logic [11:0] base, base_n;
`else
    localparam logic [11:0] base = 12'd0;
`endif

    assign cur_idx  = {7'd0, row} * TERM_W12 + {5'd0, col};
    assign accept   = in_valid && (state == ST_IDLE);
    assign disp_oor = disp_idx >= TERM_N12;
    assign rd_addr  = disp_oor ? 12'd0 : wrap_addr(disp_idx, base);

    // Next-state, cursor update and RAM write decode.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        row_n   = row;
        col_n   = col;
`ifdef VGA_TERM_SCROLL_EN
        base_n  = base;
`endif
        wr_en   = 1'b0;
        wr_addr = 12'd0;
        wr_data = FILL_CHAR;
        do_nl   = 1'b0;
        case (state)
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = cnt;
                if (cnt == TERM_N12 - 12'd1) begin
                    state_n = ST_IDLE;
                    cnt_n   = 12'd0;
                end else begin
                    cnt_n = cnt + 12'd1;
                end
            end
`ifdef VGA_TERM_SCROLL_EN
            ST_SCROLL_CLR: begin
                // The newly exposed bottom row, addressed logically.
                wr_en   = 1'b1;
                wr_addr = wrap_addr(LAST_ROW_IDX + cnt, base);
                if (cnt == TERM_W12 - 12'd1) begin
                    state_n = ST_IDLE;
                    cnt_n   = 12'd0;
                end else begin
                    cnt_n = cnt + 12'd1;
                end
            end
`endif
            default: begin
                if (accept) begin
                    unique case (1'b1)
                        (in_char >= PRINT_LO && in_char <= PRINT_HI): begin
                            wr_en   = 1'b1;
                            wr_addr = wrap_addr(cur_idx, base);
                            wr_data = in_char;
                            if (col == 7'(TERM_W - 1))
                                do_nl = 1'b1;
                            else
                                col_n = col + 7'd1;
                        end
                        (in_char == CH_LF): do_nl = 1'b1;
                        (in_char == CH_CR): col_n = 7'd0;
                        (in_char == CH_BS): begin
                            if (col != 7'd0) begin
                                col_n   = col - 7'd1;
                                wr_en   = 1'b1;
                                wr_addr = wrap_addr(cur_idx - 12'd1, base);
                            end
                        end
                        default: ;
                    endcase
                    if (do_nl) begin
                        col_n = 7'd0;
                        if (row != 5'(TERM_H - 1)) begin
                            row_n = row + 5'd1;
                        end else begin
`ifdef VGA_TERM_SCROLL_EN
                            base_n  = (base == LAST_ROW_IDX) ?
                                      12'd0 : base + TERM_W12;
                            state_n = ST_SCROLL_CLR;
                            cnt_n   = 12'd0;
`else
                            row_n = 5'd0;
`endif
                        end
                    end
                end
            end
        endcase
    end

    // State, cursor and ring offset registers.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state  <= ST_CLEAR;
            cnt    <= 12'd0;
            row    <= 5'd0;
            col    <= 7'd0;
            fill_q <= 1'b1;
`ifdef VGA_TERM_SCROLL_EN
            base   <= 12'd0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            row    <= row_n;
            col    <= col_n;
            fill_q <= disp_oor;
`ifdef VGA_TERM_SCROLL_EN
            base   <= base_n;
`endif
        end
    end

    term_ram u_ram (
        .clk     (clk_50M),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    assign in_ready  = (state == ST_IDLE);
    assign busy      = !in_ready;
    assign cur_row   = row;
    assign cur_col   = col;
    assign disp_char = fill_q ? FILL_CHAR : ram_q;

endmodule

// File: tb/tb_vga_term_ctrl.sv
// Directed bench for vga_term_ctrl with a display-read scoreboard.
// Covers both VGA_TERM_SCROLL_EN builds.
module tb_vga_term_ctrl;

    logic        clk_50M = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic [11:0] disp_idx;
    logic [7:0]  disp_char;
    logic [4:0]  cur_row;
    logic [6:0]  cur_col;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk_50M = ~clk_50M;

    vga_term_ctrl dut (
        .clk_50M   (clk_50M),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .disp_idx  (disp_idx),
        .disp_char (disp_char),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int idx, input logic [7:0] exp);
        logic [7:0] e;
        exp_q.push_back(exp);
        disp_idx = 12'(idx);
        tick();
        e = exp_q.pop_front();
        chk($sformatf("disp[%0d]", idx), 32'(disp_char), 32'(e));
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!in_ready && n < budget) begin
            tick();
            n++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] c);
        wait_ready(3000);
        in_valid = 1'b1;
        in_char  = c;
        tick();
        in_valid = 1'b0;
        in_char  = 8'h00;
    endtask

    // Called right after rst is released; checks exact CLEAR length.
    task automatic clear_seq();
        repeat (2099) tick();
        chk("clear_ready_lo", 32'(in_ready), 32'd0);
        chk("clear_busy_hi", 32'(busy), 32'd1);
        tick();
        chk("clear_ready_hi", 32'(in_ready), 32'd1);
        chk("clear_busy_lo", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_char  = 8'h00;
        disp_idx = 12'd0;
        tick();
        tick();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_row", 32'(cur_row), 32'd0);
        chk("rst_col", 32'(cur_col), 32'd0);
        chk("rst_disp", 32'(disp_char), 32'h20);

        // Reset in the middle of CLEAR restarts the full sweep.
        rst = 1'b0;
        repeat (500) tick();
        chk("midclr_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_seq();

        for (int i = 0; i < 2100; i++)
            rd(i, 8'h20);
        rd(2100, 8'h20);
        rd(4095, 8'h20);

        send(8'h41);
        send(8'h42);
        rd(0, 8'h41);
        rd(1, 8'h42);
        chk("ab_col", 32'(cur_col), 32'd2);
        chk("ab_row", 32'(cur_row), 32'd0);

        send(8'h0D);
        chk("cr_col", 32'(cur_col), 32'd0);
        repeat (70) send(8'h78);
        for (int i = 0; i < 70; i++)
            rd(i, 8'h78);
        chk("wrap_row", 32'(cur_row), 32'd1);
        chk("wrap_col", 32'(cur_col), 32'd0);

        send(8'h51);
        rd(70, 8'h51);
        chk("q_col", 32'(cur_col), 32'd1);
        send(8'h08);
        rd(70, 8'h20);
        chk("bs_col", 32'(cur_col), 32'd0);
        send(8'h08);
        chk("bs0_col", 32'(cur_col), 32'd0);
        chk("bs0_row", 32'(cur_row), 32'd1);
        rd(69, 8'h78);

        // Write and read the same cell on one edge: old value first.
        wait_ready(3000);
        disp_idx = 12'd70;
        exp_q.push_back(8'h20);
        in_valid = 1'b1;
        in_char  = 8'h5A;
        tick();
        in_valid = 1'b0;
        chk("rw_old", 32'(disp_char), 32'(exp_q.pop_front()));
        rd(70, 8'h5A);

        send(8'h01);
        chk("ctl01_col", 32'(cur_col), 32'd1);
        rd(71, 8'h20);
        send(8'hFF);
        chk("ctlff_col", 32'(cur_col), 32'd1);
        send(8'h7E);
        rd(71, 8'h7E);
        chk("tilde_col", 32'(cur_col), 32'd2);
        send(8'h7F);
        send(8'h1F);
        chk("del_col", 32'(cur_col), 32'd2);
        rd(72, 8'h20);

        rst = 1'b1;
        tick();
        chk("rst2_row", 32'(cur_row), 32'd0);
        chk("rst2_col", 32'(cur_col), 32'd0);
        rst = 1'b0;
        clear_seq();
        rd(0, 8'h20);
        rd(70, 8'h20);

        // Fill each row's first 69 cells with a row-unique code.
        for (int r = 0; r < 30; r++) begin
            repeat (69) send(8'(8'h41 + r));
            if (r < 29)
                send(8'h0A);
        end
        chk("fill_row", 32'(cur_row), 32'd29);
        chk("fill_col", 32'(cur_col), 32'd69);
        send(8'h0A);

`ifdef VGA_TERM_SCROLL_EN
        for (int k = 0; k < 70; k++) begin
            chk("scr_busy", 32'(busy), 32'd1);
            chk("scr_ready", 32'(in_ready), 32'd0);
            tick();
        end
        chk("scr_done", 32'(busy), 32'd0);
        chk("scr_row", 32'(cur_row), 32'd29);
        chk("scr_col", 32'(cur_col), 32'd0);
        rd(0, 8'h42);
        rd(1960, 8'h5E);
        for (int i = 2030; i < 2100; i++)
            rd(i, 8'h20);
        send(8'h7A);
        rd(2030, 8'h7A);
        chk("scr_z_col", 32'(cur_col), 32'd1);

        send(8'h0A);
        repeat (10) tick();
        chk("scr2_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("scr_rst_row", 32'(cur_row), 32'd0);
        chk("scr_rst_col", 32'(cur_col), 32'd0);
        chk("scr_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        clear_seq();
        rd(0, 8'h20);
        rd(1000, 8'h20);
        rd(2099, 8'h20);
`else
        chk("nos_busy", 32'(busy), 32'd0);
        chk("nos_ready", 32'(in_ready), 32'd1);
        chk("nos_row", 32'(cur_row), 32'd0);
        chk("nos_col", 32'(cur_col), 32'd0);
        rd(0, 8'h41);
        rd(2030, 8'h5E);
        rd(69, 8'h20);
        rd(2099, 8'h20);
        send(8'h7A);
        rd(0, 8'h7A);
        rd(1, 8'h41);
        chk("nos_z_col", 32'(cur_col), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
